// File: rtl/result_sink.sv
// result_sink: captures result words from a DUT into a FIFO under a run/done/timeout FSM.
// Optional feature: define RESULT_SINK_CHECKSUM_EN to add an XOR checksum output port.
module result_sink #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 8,
  parameter int EXPECT_COUNT = 4,
  parameter int MAX_CYCLES   = 200
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    in_ready,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [31:0]             cycle_count,
  output logic [31:0]             accepted,
  output logic                    done,
  output logic                    timeout
`ifdef RESULT_SINK_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]   checksum
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [31:0]   EXPECT_C = 32'(EXPECT_COUNT);
  localparam logic [31:0]   MAX_C    = 32'(MAX_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [31:0]            cycle_q, cycle_d;
  logic [31:0]            accepted_q, accepted_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   done_q, done_d;
  logic                   timeout_q, timeout_d;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  logic                   push_s;
  logic                   pop_s;
  logic                   complete_s;
  logic                   budget_s;

  assign in_ready    = (state_q == ST_RUN) && (count_q < DEPTH_C);
  assign push_s      = in_valid && in_ready;
  assign pop_s       = rd_en && (count_q != {CW{1'b0}});
  assign complete_s  = push_s && ((accepted_q + 32'd1) == EXPECT_C);
  assign budget_s    = (state_q == ST_RUN) && ((cycle_q + 32'd1) == MAX_C);

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign fifo_count  = count_q;
  assign cycle_count = cycle_q;
  assign accepted    = accepted_q;
  assign done        = done_q;
  assign timeout     = timeout_q;

  // Next-state logic; completion is tested before the budget so DONE wins a tie.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (complete_s)    state_d = ST_DONE;
        else if (budget_s) state_d = ST_TIMEOUT;
        else               state_d = ST_RUN;
      end
      ST_DONE:    state_d = ST_DONE;
      ST_TIMEOUT: state_d = ST_TIMEOUT;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FIFO pointers, occupancy, run counters and read port next values.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    accepted_d = accepted_q;
    cycle_d    = cycle_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    if (push_s) begin
      wr_ptr_d   = wr_ptr_q + AW'(1'b1);
      accepted_d = accepted_q + 32'd1;
    end else begin
      wr_ptr_d   = wr_ptr_q;
      accepted_d = accepted_q;
    end

    if (pop_s) begin
      rd_ptr_d   = rd_ptr_q + AW'(1'b1);
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end else begin
      rd_ptr_d   = rd_ptr_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase

    if (state_q == ST_RUN) cycle_d = cycle_q + 32'd1;
    else                   cycle_d = cycle_q;

    done_d    = (state_d == ST_DONE);
    timeout_d = (state_d == ST_TIMEOUT);
  end

  // Control and status registers.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      cycle_q    <= 32'd0;
      accepted_q <= 32'd0;
      rd_data_q  <= {DATA_WIDTH{1'b0}};
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cycle_q    <= cycle_d;
      accepted_q <= accepted_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  // Storage array; contents are only observable through the pointers, so no reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

`ifdef RESULT_SINK_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  assign checksum = checksum_q;

  // Running XOR of accepted words; freezes once acceptance stops.
  always_comb begin
    checksum_d = checksum_q;
    if (push_s) checksum_d = checksum_q ^ in_data;
    else        checksum_d = checksum_q;
  end

  // Checksum register.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) checksum_q <= {DATA_WIDTH{1'b0}};
    else      checksum_q <= checksum_d;
  end
`endif

endmodule

// File: tb/tb_result_sink.sv
// Directed self-checking bench for result_sink: normal run, drain, backpressure,
// timeout, completion/budget tie, mid-run reset and (when enabled) checksum.
module tb_result_sink;

  logic        clk;
  logic        rst;

  // Instance A: DEPTH=8, EXPECT_COUNT=4, MAX_CYCLES=10
  logic        a_start, a_in_valid, a_in_ready, a_rd_en, a_rd_valid, a_done, a_timeout;
  logic [31:0] a_in_data, a_rd_data, a_cycle_count, a_accepted;
  logic [3:0]  a_fifo_count;
`ifdef RESULT_SINK_CHECKSUM_EN
  logic [31:0] a_checksum;
`endif

  // Instance B: DEPTH=2, EXPECT_COUNT=4, MAX_CYCLES=200
  logic        b_start, b_in_valid, b_in_ready, b_rd_en, b_rd_valid, b_done, b_timeout;
  logic [31:0] b_in_data, b_rd_data, b_cycle_count, b_accepted;
  logic [1:0]  b_fifo_count;
`ifdef RESULT_SINK_CHECKSUM_EN
  logic [31:0] b_checksum;
`endif

  int n_pass;
  int n_total;

  result_sink #(.DATA_WIDTH(32), .DEPTH(8), .EXPECT_COUNT(4), .MAX_CYCLES(10)) u_dut_a (
    .clock(clk), .rst(rst), .start(a_start), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .rd_en(a_rd_en), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .fifo_count(a_fifo_count), .cycle_count(a_cycle_count), .accepted(a_accepted),
    .done(a_done), .timeout(a_timeout)
`ifdef RESULT_SINK_CHECKSUM_EN
    , .checksum(a_checksum)
`endif
  );

  result_sink #(.DATA_WIDTH(32), .DEPTH(2), .EXPECT_COUNT(4), .MAX_CYCLES(200)) u_dut_b (
    .clock(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .fifo_count(b_fifo_count), .cycle_count(b_cycle_count), .accepted(b_accepted),
    .done(b_done), .timeout(b_timeout)
`ifdef RESULT_SINK_CHECKSUM_EN
    , .checksum(b_checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Pulse reset across one edge and release it just after a rising edge.
  task automatic reset_pulse();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    rst        = 1'b0;
    a_start    = 1'b0; a_in_valid = 1'b0; a_in_data = 32'd0; a_rd_en = 1'b0;
    b_start    = 1'b0; b_in_valid = 1'b0; b_in_data = 32'd0; b_rd_en = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_in_ready",   64'(a_in_ready),    64'd0);
    check("rst_fifo_count", 64'(a_fifo_count),  64'd0);
    check("rst_cycle",      64'(a_cycle_count), 64'd0);
    check("rst_accepted",   64'(a_accepted),    64'd0);
    check("rst_done",       64'(a_done),        64'd0);
    check("rst_timeout",    64'(a_timeout),     64'd0);
    check("rst_rd_valid",   64'(a_rd_valid),    64'd0);
    check("rst_rd_data",    64'(a_rd_data),     64'd0);
    rst = 1'b1;
    tick();
    check("idle_in_ready", 64'(a_in_ready), 64'd0);

    // Backpressure on the two-entry instance
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("bp_ready_run", 64'(b_in_ready), 64'd1);
    b_in_valid = 1'b1; b_in_data = 32'h0A;
    tick();
    check("bp_count1", 64'(b_fifo_count), 64'd1);
    check("bp_ready1", 64'(b_in_ready),   64'd1);
    b_in_data = 32'h0B;
    tick();
    check("bp_count2", 64'(b_fifo_count), 64'd2);
    check("bp_full_ready", 64'(b_in_ready), 64'd0);
    tick();
    check("bp_hold_acc", 64'(b_accepted), 64'd2);
    b_rd_en = 1'b1;
    tick();
    b_rd_en = 1'b0;
    check("bp_pop_valid", 64'(b_rd_valid), 64'd1);
    check("bp_pop_data",  64'(b_rd_data),  64'h0A);
    check("bp_pop_acc",   64'(b_accepted), 64'd2);
    check("bp_reready",   64'(b_in_ready), 64'd1);
    b_in_data = 32'h0C;
    tick();
    b_in_valid = 1'b0;
    check("bp_acc3",   64'(b_accepted),   64'd3);
    check("bp_count",  64'(b_fifo_count), 64'd2);
    check("bp_rv_off", 64'(b_rd_valid),   64'd0);

    // Normal run: 1,2,3,4 on consecutive cycles
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("run_cycle0", 64'(a_cycle_count), 64'd0);
    check("run_ready",  64'(a_in_ready),    64'd1);
    a_in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      a_in_data = 32'(i);
      if (i == 4) check("run_not_done_yet", 64'(a_done), 64'd0);
      tick();
    end
    a_in_valid = 1'b0;
    check("run_done",     64'(a_done),        64'd1);
    check("run_accepted", 64'(a_accepted),    64'd4);
    check("run_cycle",    64'(a_cycle_count), 64'd4);
    check("run_ready_off",64'(a_in_ready),    64'd0);
    check("run_count",    64'(a_fifo_count),  64'd4);
    tick();
    tick();
    check("run_cycle_hold", 64'(a_cycle_count), 64'd4);
    check("run_done_stick", 64'(a_done),        64'd1);

    // Drain: five reads, four pulses
    a_rd_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("drain_valid", 64'(a_rd_valid), 64'd1);
      check("drain_data",  64'(a_rd_data),  64'(i));
    end
    tick();
    a_rd_en = 1'b0;
    check("drain_no_fifth", 64'(a_rd_valid),   64'd0);
    check("drain_hold",     64'(a_rd_data),    64'd4);
    check("drain_empty",    64'(a_fifo_count), 64'd0);

    // Timeout with no traffic
    reset_pulse();
    check("to_rst_done", 64'(a_done), 64'd0);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("to_cycle9",   64'(a_cycle_count), 64'd9);
    check("to_not_yet",  64'(a_timeout),     64'd0);
    tick();
    check("to_timeout",  64'(a_timeout),     64'd1);
    check("to_cycle10",  64'(a_cycle_count), 64'd10);
    check("to_not_done", 64'(a_done),        64'd0);
    a_in_valid = 1'b1; a_in_data = 32'h55;
    tick();
    a_in_valid = 1'b0;
    check("to_no_accept", 64'(a_accepted),    64'd0);
    check("to_no_push",   64'(a_fifo_count),  64'd0);
    check("to_cycle_hold",64'(a_cycle_count), 64'd10);

    // Tie: fourth word accepted on the budget edge
    reset_pulse();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    a_in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      a_in_data = 32'(i + 16);
      tick();
    end
    a_in_valid = 1'b0;
    check("tie_cycle",   64'(a_cycle_count), 64'd10);
    check("tie_done",    64'(a_done),        64'd1);
    check("tie_timeout", 64'(a_timeout),     64'd0);

    // Mid-run reset with two words stored
    reset_pulse();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_in_valid = 1'b1;
    a_in_data = 32'h11;
    tick();
    a_in_data = 32'h22;
    tick();
    a_in_valid = 1'b0;
    check("mr_count2", 64'(a_fifo_count), 64'd2);
    #2;
    rst = 1'b0;
    #1;
    check("mr_count0", 64'(a_fifo_count),  64'd0);
    check("mr_acc0",   64'(a_accepted),    64'd0);
    check("mr_cycle0", 64'(a_cycle_count), 64'd0);
    check("mr_ready0", 64'(a_in_ready),    64'd0);
    a_start = 1'b1;
    tick();
    check("mr_start_ignored", 64'(a_in_ready), 64'd0);
    a_start = 1'b0;
    rst = 1'b1;
    tick();
    check("mr_still_idle", 64'(a_in_ready), 64'd0);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("mr_restart", 64'(a_in_ready), 64'd1);

`ifdef RESULT_SINK_CHECKSUM_EN
    // Checksum over F0, 0F, FF, 01
    reset_pulse();
    check("cs_rst", 64'(a_checksum), 64'd0);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_in_valid = 1'b1;
    a_in_data = 32'hF0; tick();
    a_in_data = 32'h0F; tick();
    a_in_data = 32'hFF; tick();
    a_in_data = 32'h01; tick();
    a_in_data = 32'h80; tick();
    a_in_valid = 1'b0;
    check("cs_value", 64'(a_checksum), 64'h01);
    check("cs_done",  64'(a_done),     64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
